// File: rtl/ltc2208_pkg.sv
// Shared encodings for the LTC2208 ADC-bus emulator: mode codes, FSM states, PRBS15 taps.
package ltc2208_pkg;

  localparam logic [1:0] MODE_CONST  = 2'd0;
  localparam logic [1:0] MODE_RAMP   = 2'd1;
  localparam logic [1:0] MODE_PRBS   = 2'd2;
  localparam logic [1:0] MODE_STREAM = 2'd3;

  typedef enum logic [2:0] {
    ST_CONST,
    ST_RAMP,
    ST_PRBS,
    ST_PRIME,
    ST_STREAM
  } state_t;

  localparam int PRBS_TAP_A = 14;
  localparam int PRBS_TAP_B = 13;
  localparam logic [14:0] PRBS_DEFAULT_SEED = 15'h7FFF;

  // STREAM is always entered through PRIME so nothing is replayed before the first beat.
  function automatic state_t mode_to_state(input logic [1:0] m);
    case (m)
      MODE_RAMP:   return ST_RAMP;
      MODE_PRBS:   return ST_PRBS;
      MODE_STREAM: return ST_PRIME;
      default:     return ST_CONST;
    endcase
  endfunction

endpackage

// File: rtl/ltc2208_randomise.sv
// Stage-2 output register applying the LTC2208 output randomiser
// (bit0 set -> complement all upper bits).
module ltc2208_randomise
  import ltc2208_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rand_sel,
  input  logic [DATA_W-1:0] din,
  input  logic              din_valid,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid
);

  logic [DATA_W-1:0] dout_p2;
  logic              vld_p2;

  function automatic logic [DATA_W-1:0] randomise(input logic sel, input logic [DATA_W-1:0] x);
    if (sel && x[0]) return {~x[DATA_W-1:1], x[0]};
    return x;
  endfunction

  // ---- stage 2: randomised output register ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p2  <= 1'b0;
      dout_p2 <= '0;
    end else begin
      vld_p2 <= din_valid;
      if (din_valid) dout_p2 <= randomise(rand_sel, din);
    end
  end

  assign dout       = dout_p2;
  assign dout_valid = vld_p2;

endmodule

// File: rtl/ltc2208_sample_source.sv
// LTC2208 ADC output-bus emulator: mode FSM and sample generators (stage 1)
// feeding the randomiser register (stage 2).
module ltc2208_sample_source
  import ltc2208_pkg::*;
#(
  parameter int          DATA_WIDTH = 16,
  parameter logic [14:0] PRBS_SEED  = 15'h7FFF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  sample_en,
  input  logic                  rand_sel,
  input  logic [1:0]            mode,
  input  logic [DATA_WIDTH-1:0] const_val,
  input  logic [DATA_WIDTH-1:0] ramp_step,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  output logic [1:0]            mode_active,
  output logic [15:0]           underrun_cnt
);

  localparam logic [14:0] SEED = (PRBS_SEED == 15'd0) ? PRBS_DEFAULT_SEED : PRBS_SEED;

  state_t                state_q, state_d;
  logic [1:0]            mode_active_q;
  logic [DATA_WIDTH-1:0] acc_q, acc_d;
  logic [14:0]           lfsr_q, lfsr_d;
  logic [DATA_WIDTH-1:0] last_q, last_d;
  logic [15:0]           under_q, under_d;
  logic [DATA_WIDTH-1:0] raw_d;
  logic [DATA_WIDTH-1:0] raw_p1;
  logic                  vld_p1;
  logic                  fb;
  logic                  mode_change;
  logic                  stream_state;

  assign fb            = lfsr_q[PRBS_TAP_A] ^ lfsr_q[PRBS_TAP_B];
  assign mode_change   = (mode != mode_active_q);
  assign stream_state  = (state_q == ST_PRIME) || (state_q == ST_STREAM);
  assign s_axis_tready = sample_en && stream_state;

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    lfsr_d  = lfsr_q;
    last_d  = last_q;
    under_d = under_q;
    raw_d   = '0;
    if (sample_en) begin
      case (state_q)
        ST_CONST: raw_d = const_val;
        ST_RAMP: begin
          raw_d = acc_q;
          acc_d = acc_q + ramp_step;
        end
        ST_PRBS: begin
          raw_d  = {lfsr_q, {(DATA_WIDTH-15){fb}}};
          lfsr_d = {lfsr_q[13:0], fb};
        end
        ST_PRIME: begin
          if (s_axis_tvalid) begin
            raw_d   = s_axis_tdata;
            last_d  = s_axis_tdata;
            state_d = ST_STREAM;
          end
        end
        ST_STREAM: begin
          if (s_axis_tvalid) begin
            raw_d  = s_axis_tdata;
            last_d = s_axis_tdata;
          end else begin
            raw_d = last_q;
            if (under_q != 16'hFFFF) under_d = under_q + 16'd1;
          end
        end
        default: raw_d = '0;
      endcase
    end
    // A coinciding sample still comes from the old mode; only generator state is reloaded.
    if (mode_change) begin
      state_d = mode_to_state(mode);
      acc_d   = '0;
      lfsr_d  = SEED;
      under_d = '0;
    end
  end

  // ---- stage 1: generator state and raw sample ----
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_CONST;
      mode_active_q <= MODE_CONST;
      acc_q         <= '0;
      lfsr_q        <= SEED;
      under_q       <= '0;
      vld_p1        <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_active_q <= mode;
      acc_q         <= acc_d;
      lfsr_q        <= lfsr_d;
      under_q       <= under_d;
      vld_p1        <= sample_en;
    end
  end

  always_ff @(posedge clk) begin
    last_q <= last_d;
    if (sample_en) raw_p1 <= raw_d;
  end

  // ---- stage 2 ----
  ltc2208_randomise #(.DATA_W(DATA_WIDTH)) u_randomise (
    .clk        (clk),
    .rst        (rst),
    .rand_sel   (rand_sel),
    .din        (raw_p1),
    .din_valid  (vld_p1),
    .dout       (dout),
    .dout_valid (dout_valid)
  );

  assign mode_active  = mode_active_q;
  assign underrun_cnt = under_q;

endmodule

// File: tb/tb_ltc2208_sample_source.sv
// Scoreboard bench for ltc2208_sample_source: behavioural generator model feeds an
// expected-sample queue; a negedge monitor checks dout and the de-randomised loopback.
module tb_ltc2208_sample_source;
  import ltc2208_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sample_en = 1'b0;
  logic        rand_sel = 1'b0;
  logic [1:0]  mode = MODE_CONST;
  logic [15:0] const_val = '0;
  logic [15:0] ramp_step = '0;
  logic [15:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tready;
  logic [15:0] dout;
  logic        dout_valid;
  logic [1:0]  mode_active;
  logic [15:0] underrun_cnt;

  ltc2208_sample_source #(.DATA_WIDTH(16), .PRBS_SEED(15'h0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .sample_en     (sample_en),
    .rand_sel      (rand_sel),
    .mode          (mode),
    .const_val     (const_val),
    .ramp_step     (ramp_step),
    .s_axis_tdata  (tdata),
    .s_axis_tvalid (tvalid),
    .s_axis_tready (tready),
    .dout          (dout),
    .dout_valid    (dout_valid),
    .mode_active   (mode_active),
    .underrun_cnt  (underrun_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] raw;
    logic        rs;
  } exp_t;

  exp_t        sbq[$];
  int          n_vec = 0;
  int          n_bad = 0;

  logic [1:0]  m_mode;
  logic [15:0] m_acc;
  int          m_pidx;
  logic        m_primed;
  logic [15:0] m_last;
  int          m_under;
  logic [15:0] prbs_tab[32767];

  function automatic logic [15:0] rnd(input logic rs, input logic [15:0] r);
    return (rs && r[0]) ? {~r[15:1], r[0]} : r;
  endfunction

  function automatic logic [15:0] derand(input logic [15:0] d);
    return d[0] ? (d ^ 16'hFFFE) : d;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode   = MODE_CONST;
    m_acc    = '0;
    m_pidx   = 0;
    m_primed = 1'b0;
    m_under  = 0;
  endtask

  // Model the inputs currently driven, then advance one clock edge.
  task automatic tick();
    exp_t        e;
    logic [15:0] raw;
    #1;
    if (!rst) check("tready", tready, sample_en && (m_mode == MODE_STREAM));
    if (rst) begin
      model_reset();
    end else begin
      if (sample_en) begin
        raw = '0;
        case (m_mode)
          MODE_CONST: raw = const_val;
          MODE_RAMP: begin
            raw   = m_acc;
            m_acc = m_acc + ramp_step;
          end
          MODE_PRBS: begin
            raw    = prbs_tab[m_pidx];
            m_pidx = (m_pidx + 1) % 32767;
          end
          default: begin
            if (tvalid) begin
              raw      = tdata;
              m_last   = tdata;
              m_primed = 1'b1;
            end else if (m_primed) begin
              raw = m_last;
              if (m_under < 65535) m_under++;
            end
          end
        endcase
        e.raw = raw;
        e.rs  = rand_sel;
        sbq.push_back(e);
      end
      if (mode != m_mode) begin
        m_mode   = mode;
        m_acc    = '0;
        m_pidx   = 0;
        m_primed = 1'b0;
        m_under  = 0;
      end
    end
    @(posedge clk);
    #1;
    if (rst) sbq.delete();
  endtask

  task automatic drain();
    sample_en = 1'b0;
    repeat (3) tick();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (dout_valid) begin
      if (sbq.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL unexpected_sample: got %0h, expected no output at %0t", dout, $time);
      end else begin
        e = sbq.pop_front();
        check("dout", dout, rnd(e.rs, e.raw));
        if (e.rs) check("loopback", derand(dout), e.raw);
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [15:0] cv_tab [3] = '{16'h0001, 16'h1234, 16'h8003};
  logic [15:0] ce_tab [3] = '{16'hFFFF, 16'h1234, 16'h7FFD};

  initial begin
    logic [14:0] l;
    logic        f;
    l = 15'h7FFF;
    for (int i = 0; i < 32767; i++) begin
      f = l[14] ^ l[13];
      prbs_tab[i] = {l, f};
      l = {l[13:0], f};
    end
    model_reset();

    // Reset state
    rst = 1'b1;
    tick();
    tick();
    check("rst_dout", dout, 16'h0000);
    check("rst_valid", dout_valid, 1'b0);
    check("rst_mode_active", mode_active, MODE_CONST);
    check("rst_underrun", underrun_cnt, 16'h0000);
    rst = 1'b0;

    // CONST through the randomiser
    rand_sel = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      const_val = cv_tab[i];
      sample_en = 1'b1;
      tick();
      drain();
      check("const_rand", dout, ce_tab[i]);
    end
    rand_sel  = 1'b0;
    const_val = 16'h8003;
    sample_en = 1'b1;
    tick();
    drain();
    check("const_plain", dout, 16'h8003);
    rand_sel = 1'b1;
    drain();

    // RAMP step 1: latency from the first sample_en cycle
    rst       = 1'b1;
    mode      = MODE_RAMP;
    ramp_step = 16'd1;
    tick();
    rst = 1'b0;
    tick();
    check("ramp_mode_active", mode_active, MODE_RAMP);
    sample_en = 1'b1;
    tick();
    check("ramp_lat_valid0", dout_valid, 1'b0);
    tick();
    check("ramp_lat_valid1", dout_valid, 1'b1);
    check("ramp_first", dout, 16'h0000);
    repeat (20) tick();

    // Reset mid-ramp kills the samples in flight
    rst = 1'b1;
    tick();
    check("midrst_dout", dout, 16'h0000);
    check("midrst_valid", dout_valid, 1'b0);
    rst       = 1'b0;
    sample_en = 1'b0;
    tick();
    ramp_step = 16'h8000;
    sample_en = 1'b1;
    repeat (8) tick();
    ramp_step = 16'hFFFF;
    repeat (8) tick();

    // RAMP -> PRBS on a sample cycle
    ramp_step = 16'd3;
    repeat (4) tick();
    mode = MODE_PRBS;
    #1;
    check("switch_before", mode_active, MODE_RAMP);
    tick();
    check("switch_after", mode_active, MODE_PRBS);
    repeat (1000) tick();
    drain();

    // STREAM: prime, data, underruns
    mode = MODE_STREAM;
    tick();
    tvalid    = 1'b0;
    sample_en = 1'b1;
    repeat (2) tick();
    tvalid = 1'b1;
    tdata  = 16'hA5A5;
    tick();
    tdata = 16'h3C3D;
    tick();
    tvalid = 1'b0;
    repeat (3) tick();
    drain();
    check("underrun_3", underrun_cnt, 16'd3);
    check("stream_last", dout, rnd(1'b1, 16'h3C3D));
    sample_en = 1'b1;
    repeat (70000) tick();
    drain();
    check("underrun_sat", underrun_cnt, 16'hFFFF);
    mode = MODE_CONST;
    tick();
    check("underrun_clear", underrun_cnt, 16'h0000);
    drain();

    // Randomised mixed traffic
    for (int blk = 0; blk < 4; blk++) begin
      rand_sel = 1'($urandom_range(0, 1));
      for (int c = 0; c < 1500; c++) begin
        sample_en = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 39) == 0) mode = 2'($urandom_range(0, 3));
        tvalid    = ($urandom_range(0, 2) != 0);
        tdata     = 16'($urandom);
        const_val = 16'($urandom);
        ramp_step = 16'($urandom);
        tick();
      end
      drain();
      check("rand_mode_active", mode_active, m_mode);
      check("rand_underrun", underrun_cnt, 16'(m_under));
    end

    check("scoreboard_empty", sbq.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
